// File: rtl/mem_bist_initiator.sv
// ---------------------------------------------------------------------------
// MemBistInitiator -- request-side built-in self-test engine for mem_intf.
//
// Runs a write sweep over [start_addr, end_addr] (inclusive, wrapping modulo
// 2^ADDR_W) and then a read sweep over the same range. Each read is checked
// against SEED ^ addr, which is exactly the value written to that address.
// Every access costs at least two cycles: one request cycle plus one gap cycle.
//
// Ports:
//   clk_i            clock, all logic on the rising edge
//   rst_i            synchronous active-high reset
//   start_i          one-cycle pulse, starts a sweep when idle
//   start_addr_i     first address, sampled with start_i
//   end_addr_i       last address (inclusive), sampled with start_i
//   req_vld_o        request valid towards mem_intf
//   req_rnw_o        1 = read, 0 = write
//   req_addr_o       request address
//   wdata_o          write data (SEED ^ addr, also driven during reads)
//   req_rdy_i        mem_intf accepts the request; rdata_i valid same cycle
//   rdata_i          read data
//   busy_o           sweep in progress
//   done_o           sweep finished, held until the next accepted start
//   pass_o           done with no mismatches (and no timeout)
//   err_cnt_o        saturating count of read mismatches
//   first_err_addr_o address of the first mismatch, 0 if none
//   timeout_o        watchdog expired (only with MEM_BIST_TIMEOUT_EN)
//
// Optional feature macro: MEM_BIST_TIMEOUT_EN
//   Adds timeout_o and a watchdog that abandons the sweep once a request has
//   been stalled for TIMEOUT_CYC consecutive cycles.
// ---------------------------------------------------------------------------
module mem_bist_initiator #(
    parameter int                 ADDR_W      = 4,
    parameter int                 DATA_W      = 32,
    parameter logic [DATA_W-1:0]  SEED        = 32'hC0DE_0000,
    parameter int                 CNT_W       = 8,
    parameter int                 TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    output logic              req_vld_o,
    output logic              req_rnw_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              req_rdy_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o
`ifdef MEM_BIST_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        FINISH
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   start_q;
    logic [ADDR_W-1:0]   end_q;
    logic [ADDR_W-1:0]   cur_q;
    logic                req_vld_q;
    logic                req_rnw_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [CNT_W-1:0]    err_cnt_q;
    logic [ADDR_W-1:0]   first_err_addr_q;

`ifdef MEM_BIST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wd_q;
    logic                timeout_q;
`endif

    // Value written to (and expected back from) a given address.
    function automatic logic [DATA_W-1:0] patternFor(input logic [ADDR_W-1:0] addr);
        return SEED ^ DATA_W'(addr);
    endfunction

    // Single FSM with all outputs registered. Request outputs are loaded on
    // entry to a REQ state and left untouched while stalled, so they stay
    // stable until the accept cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            start_q          <= '0;
            end_q            <= '0;
            cur_q            <= '0;
            req_vld_q        <= 1'b0;
            req_rnw_q        <= 1'b0;
            req_addr_q       <= '0;
            wdata_q          <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
`ifdef MEM_BIST_TIMEOUT_EN
            wd_q             <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
`ifdef MEM_BIST_TIMEOUT_EN
            // Counts consecutive stalled request cycles; any cycle that is not
            // a stall (accept, gap, idle) clears it, which covers REQ entry.
            if (req_vld_q && !req_rdy_i) begin
                wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        start_q          <= start_addr_i;
                        end_q            <= end_addr_i;
                        cur_q            <= start_addr_i;
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        err_cnt_q        <= '0;
                        first_err_addr_q <= '0;
                        req_vld_q        <= 1'b1;
                        req_rnw_q        <= 1'b0;
                        req_addr_q       <= start_addr_i;
                        wdata_q          <= patternFor(start_addr_i);
`ifdef MEM_BIST_TIMEOUT_EN
                        timeout_q        <= 1'b0;
`endif
                        state_q          <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (req_rdy_i) begin
                        req_vld_q <= 1'b0;
                        state_q   <= WR_GAP;
                    end
                end
                WR_GAP: begin
                    // Last write done: restart at the first address for reads.
                    if (cur_q == end_q) begin
                        cur_q      <= start_q;
                        req_rnw_q  <= 1'b1;
                        req_addr_q <= start_q;
                        wdata_q    <= patternFor(start_q);
                        state_q    <= RD_REQ;
                    end else begin
                        cur_q      <= cur_q + 1'b1;
                        req_addr_q <= cur_q + 1'b1;
                        wdata_q    <= patternFor(cur_q + 1'b1);
                        state_q    <= WR_REQ;
                    end
                    req_vld_q <= 1'b1;
                end
                RD_REQ: begin
                    if (req_rdy_i) begin
                        if (rdata_i != patternFor(cur_q)) begin
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                            if (err_cnt_q == '0) begin
                                first_err_addr_q <= cur_q;
                            end
                        end
                        req_vld_q <= 1'b0;
                        state_q   <= RD_GAP;
                    end
                end
                RD_GAP: begin
                    if (cur_q == end_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_q == '0);
                        state_q <= FINISH;
                    end else begin
                        cur_q      <= cur_q + 1'b1;
                        req_addr_q <= cur_q + 1'b1;
                        wdata_q    <= patternFor(cur_q + 1'b1);
                        req_vld_q  <= 1'b1;
                        state_q    <= RD_REQ;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef MEM_BIST_TIMEOUT_EN
            // Watchdog expiry overrides whatever the REQ state decided.
            if (req_vld_q && !req_rdy_i && wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                req_vld_q <= 1'b0;
                timeout_q <= 1'b1;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                pass_q    <= 1'b0;
                state_q   <= FINISH;
            end
`endif
        end
    end

    assign req_vld_o        = req_vld_q;
    assign req_rnw_o        = req_rnw_q;
    assign req_addr_o       = req_addr_q;
    assign wdata_o          = wdata_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_addr_q;
`ifdef MEM_BIST_TIMEOUT_EN
    assign timeout_o        = timeout_q;
`endif

endmodule

// File: tb/tb_mem_bist_initiator.sv
// ---------------------------------------------------------------------------
// Testbench for mem_bist_initiator. A small memory model answers requests
// with a programmable wait, and can corrupt read data at one address. Each
// scenario task drives a sweep and checks results against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_mem_bist_initiator;

    localparam logic [31:0] SEED = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  startAddr = 4'h0;
    logic [3:0]  endAddr = 4'h0;
    logic        reqVld;
    logic        reqRnw;
    logic [3:0]  reqAddr;
    logic [31:0] wdata;
    logic        reqRdy = 1'b0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  errCnt;
    logic [3:0]  firstErrAddr;
`ifdef MEM_BIST_TIMEOUT_EN
    logic        timeout;
`endif

    // Memory model controls, written only by the main initial block.
    int          waitCycles = 0;
    bit          rdyTie = 1'b0;
    bit          rdyNever = 1'b0;
    bit          corruptEn = 1'b0;
    logic [3:0]  corruptAddr = 4'h0;

    // Memory model state, written only by the model process.
    logic [31:0] mem [0:15];
    int          waitCnt = 0;
    int          logCount = 0;
    bit          logRnw [0:255];
    logic [3:0]  logAddr [0:255];
    logic [31:0] logData [0:255];

    int          checks = 0;
    int          errors = 0;

    mem_bist_initiator dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .start_addr_i     (startAddr),
        .end_addr_i       (endAddr),
        .req_vld_o        (reqVld),
        .req_rnw_o        (reqRnw),
        .req_addr_o       (reqAddr),
        .wdata_o          (wdata),
        .req_rdy_i        (reqRdy),
        .rdata_i          (rdata),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_cnt_o        (errCnt),
        .first_err_addr_o (firstErrAddr)
`ifdef MEM_BIST_TIMEOUT_EN
        ,
        .timeout_o        (timeout)
`endif
    );

    always #5 clk = ~clk;

    assign rdata = mem[reqAddr] ^ ((corruptEn && reqRnw && reqAddr == corruptAddr) ? 32'h0000_0100 : 32'h0);

    // Memory model: decides on each falling edge whether the pending request
    // is accepted at the next rising edge, and logs every accepted request.
    always @(negedge clk) begin
        if (reqVld) begin
            if (!rdyNever && (rdyTie || waitCnt >= waitCycles)) begin
                reqRdy <= 1'b1;
                if (!reqRnw) mem[reqAddr] <= wdata;
                if (logCount < 256) begin
                    logRnw[logCount]  <= reqRnw;
                    logAddr[logCount] <= reqAddr;
                    logData[logCount] <= wdata;
                end
                logCount <= logCount + 1;
                waitCnt  <= 0;
            end else begin
                reqRdy  <= 1'b0;
                waitCnt <= waitCnt + 1;
            end
        end else begin
            reqRdy  <= rdyTie && !rdyNever;
            waitCnt <= 0;
        end
    end

    task automatic startSweep(input logic [3:0] s, input logic [3:0] e);
        @(negedge clk);
        start     = 1'b1;
        startAddr = s;
        endAddr   = e;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (reqVld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b want 0", reqVld); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        if (pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got %b want 0", pass); end
        if (errCnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err got %0d want 0", errCnt); end
        if (firstErrAddr !== 4'd0) begin errors++; $display("[TB] FAIL reset_first got %0d want 0", firstErrAddr); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int base;
        bit ok;
        logic [3:0] expAddr [0:5];
        expAddr = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
        waitCycles = 2;
        rdyTie = 1'b0;
        base = logCount;
        startSweep(4'd1, 4'd3);
        checks += 5;
        if (reqVld !== 1'b1) begin errors++; $display("[TB] FAIL basic_first_vld got %b want 1", reqVld); end
        if (reqRnw !== 1'b0) begin errors++; $display("[TB] FAIL basic_first_rnw got %b want 0", reqRnw); end
        if (reqAddr !== 4'd1) begin errors++; $display("[TB] FAIL basic_first_addr got %0d want 1", reqAddr); end
        if (wdata !== 32'hC0DE_0001) begin errors++; $display("[TB] FAIL basic_first_wdata got %h want c0de0001", wdata); end
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        @(negedge clk);
        checks += 2;
        if (reqVld !== 1'b1) begin errors++; $display("[TB] FAIL basic_stall_vld got %b want 1", reqVld); end
        if (reqAddr !== 4'd1 || wdata !== 32'hC0DE_0001 || reqRnw !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_stall_hold got addr %0d data %h rnw %b want 1 c0de0001 0", reqAddr, wdata, reqRnw);
        end
        waitDone(200, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL basic_done_timeout got no done want done within 200 cycles"); end
        checks++;
        if (logCount - base !== 6) begin errors++; $display("[TB] FAIL basic_count got %0d want 6", logCount - base); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (logRnw[base + k] !== (k >= 3) || logAddr[base + k] !== expAddr[k]) begin
                errors++; $display("[TB] FAIL basic_txn%0d got rnw %b addr %0d want rnw %b addr %0d", k, logRnw[base + k], logAddr[base + k], (k >= 3), expAddr[k]);
            end
            checks++;
            if (logData[base + k] !== (SEED ^ {28'd0, expAddr[k]})) begin
                errors++; $display("[TB] FAIL basic_data%0d got %h want %h", k, logData[base + k], SEED ^ {28'd0, expAddr[k]});
            end
        end
        checks += 4;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done got %b want 1", done); end
        if (pass !== 1'b1) begin errors++; $display("[TB] FAIL basic_pass got %b want 1", pass); end
        if (errCnt !== 8'd0) begin errors++; $display("[TB] FAIL basic_err got %0d want 0", errCnt); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end got %b want 0", busy); end
    endtask

    task automatic test_corrupt();
        bit ok;
        waitCycles = 2;
        corruptEn = 1'b1;
        corruptAddr = 4'd2;
        startSweep(4'd1, 4'd3);
        waitDone(200, ok);
        corruptEn = 1'b0;
        checks += 5;
        if (!ok) begin errors++; $display("[TB] FAIL corrupt_done_timeout got no done want done within 200 cycles"); end
        if (errCnt !== 8'd1) begin errors++; $display("[TB] FAIL corrupt_err got %0d want 1", errCnt); end
        if (firstErrAddr !== 4'd2) begin errors++; $display("[TB] FAIL corrupt_first got %0d want 2", firstErrAddr); end
        if (pass !== 1'b0) begin errors++; $display("[TB] FAIL corrupt_pass got %b want 0", pass); end
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL corrupt_done got %b want 1", done); end
    endtask

    task automatic test_wrap();
        int base;
        bit ok;
        logic [3:0] order [0:3];
        order = '{4'hE, 4'hF, 4'h0, 4'h1};
        rdyTie = 1'b1;
        base = logCount;
        startSweep(4'hE, 4'h1);
        waitDone(200, ok);
        checks += 3;
        if (!ok) begin errors++; $display("[TB] FAIL wrap_done_timeout got no done want done within 200 cycles"); end
        if (logCount - base !== 8) begin errors++; $display("[TB] FAIL wrap_count got %0d want 8", logCount - base); end
        if (pass !== 1'b1 || errCnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_pass got pass %b err %0d want 1 0", pass, errCnt); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (logRnw[base + k] !== (k >= 4) || logAddr[base + k] !== order[k % 4]
                || logData[base + k] !== (SEED ^ {28'd0, order[k % 4]})) begin
                errors++; $display("[TB] FAIL wrap_txn%0d got rnw %b addr %h data %h want rnw %b addr %h", k, logRnw[base + k], logAddr[base + k], logData[base + k], (k >= 4), order[k % 4]);
            end
        end
        rdyTie = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base;
        rdyTie = 1'b1;
        base = logCount;
        startSweep(4'd5, 4'd5);
        // Cycle 1: write request; also pulse start with other addresses.
        checks++;
        if (reqVld !== 1'b1 || reqRnw !== 1'b0 || reqAddr !== 4'd5) begin
            errors++; $display("[TB] FAIL single_wr got vld %b rnw %b addr %0d want 1 0 5", reqVld, reqRnw, reqAddr);
        end
        start = 1'b1;
        startAddr = 4'd9;
        endAddr = 4'd9;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (reqVld !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL single_wgap got vld %b busy %b want 0 1", reqVld, busy);
        end
        @(negedge clk);
        checks++;
        if (reqVld !== 1'b1 || reqRnw !== 1'b1 || reqAddr !== 4'd5 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL single_rd got vld %b rnw %b addr %0d busy %b want 1 1 5 1", reqVld, reqRnw, reqAddr, busy);
        end
        @(negedge clk);
        checks++;
        if (reqVld !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL single_rgap got vld %b done %b want 0 0", reqVld, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
            errors++; $display("[TB] FAIL single_finish got done %b busy %b pass %b want 1 0 1", done, busy, pass);
        end
        repeat (3) @(negedge clk);
        checks += 2;
        if (logCount - base !== 2) begin errors++; $display("[TB] FAIL single_count got %0d want 2", logCount - base); end
        if (reqVld !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL single_idle got vld %b done %b want 0 1", reqVld, done); end
        rdyTie = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        rdyNever = 1'b1;
        startSweep(4'd0, 4'd3);
        @(negedge clk);
        checks++;
        if (reqVld !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_vld got %b want 1", reqVld); end
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (reqVld !== 1'b0) begin errors++; $display("[TB] FAIL midrst_vld got %b want 0", reqVld); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got %b want 0", done); end
        rst = 1'b0;
        rdyNever = 1'b0;
        waitCycles = 0;
        @(negedge clk);
        base = logCount;
        startSweep(4'd0, 4'd3);
        waitDone(200, ok);
        checks += 3;
        if (!ok) begin errors++; $display("[TB] FAIL midrst_done_timeout got no done want done within 200 cycles"); end
        if (pass !== 1'b1 || errCnt !== 8'd0) begin errors++; $display("[TB] FAIL midrst_pass got pass %b err %0d want 1 0", pass, errCnt); end
        if (logCount - base !== 8) begin errors++; $display("[TB] FAIL midrst_count got %0d want 8", logCount - base); end
    endtask

`ifdef MEM_BIST_TIMEOUT_EN
    task automatic test_timeout();
        int highCycles;
        rdyNever = 1'b1;
        startSweep(4'd2, 4'd4);
        highCycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (!reqVld) break;
            highCycles++;
            @(negedge clk);
        end
        checks += 5;
        if (highCycles !== 64) begin errors++; $display("[TB] FAIL timeout_cycles got %0d want 64", highCycles); end
        if (reqVld !== 1'b0) begin errors++; $display("[TB] FAIL timeout_vld got %b want 0", reqVld); end
        if (timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag got %b want 1", timeout); end
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_done got %b want 1", done); end
        if (pass !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pass got %b want 0", pass); end
        rdyNever = 1'b0;
        rdyTie = 1'b1;
        repeat (2) @(negedge clk);
        startSweep(4'd2, 4'd2);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear got %b want 0", timeout); end
        repeat (6) @(negedge clk);
        rdyTie = 1'b0;
    endtask
`endif

    initial begin
        $display("[TB] starting mem_bist_initiator bench");
        test_reset();
        test_basic();
        test_corrupt();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_BIST_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bist_initiator.md
Name: mem_bist_initiator

Overview:
Request-side initiator for the mem_intf memory responder. It runs a self-contained write-then-readback sweep over an address range and checks every read against the data it wrote. It drives the req_vld/req_rnw/req_addr/wdata bus and consumes req_rdy/rdata. It sits in front of mem_intf as a built-in self-test engine, replacing bench-driven request loops.

Parameters:
ADDR_W, 4, request address width; sweep wraps modulo 2^ADDR_W.
DATA_W, 32, write/read data width.
SEED, 32'hC0DE_0000, base pattern; wdata = SEED ^ zero-extended addr.
CNT_W, 8, error counter width; counter saturates.
TIMEOUT_CYC, 64, watchdog limit in cycles; used only with MEM_BIST_TIMEOUT_EN.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a sweep when idle.
start_addr  in  ADDR_W  first address; sampled with start.
end_addr  in  ADDR_W  last address, inclusive; sampled with start.
req_vld  out  1  request valid to mem_intf.
req_rnw  out  1  1 = read, 0 = write.
req_addr  out  ADDR_W  request address.
wdata  out  DATA_W  write data.
req_rdy  in  1  mem_intf accepts the current request; read data is valid in the same cycle.
rdata  in  DATA_W  read data; sampled only when req_vld && req_rnw && req_rdy.
busy  out  1  sweep in progress.
done  out  1  level; set at sweep end, held until the next accepted start.
pass  out  1  done && err_cnt == 0 (and no timeout).
err_cnt  out  CNT_W  count of read mismatches; saturates at all-ones.
first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State goes to IDLE.
  - req_vld, req_rnw, req_addr, wdata, busy, done, pass, err_cnt and first_err_addr all become 0.
  - Reset mid-sweep aborts with no further requests; req_vld is 0 from the next cycle.
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH.
- IDLE:
  - start=1 latches start_addr and end_addr, clears done, pass, err_cnt and first_err_addr, sets busy, and goes to WR_REQ.
  - req_vld goes high on the cycle after start.
  - start while busy is ignored.
- WR_REQ:
  - req_vld=1, req_rnw=0, req_addr=cur, wdata=SEED^cur.
  - All request outputs are held stable until req_rdy=1 (the accept cycle), then go to WR_GAP.
- WR_GAP:
  - req_vld=0 for exactly one cycle.
  - If cur==end_addr: reset cur to start_addr and go to RD_REQ.
  - Otherwise: cur=cur+1 (mod 2^ADDR_W) and go to WR_REQ.
- RD_REQ:
  - req_vld=1, req_rnw=1, req_addr=cur, held until req_rdy.
  - On the accept cycle, compare rdata with SEED^cur. On mismatch: err_cnt++ (saturating); if this is the first error, load first_err_addr=cur.
- RD_GAP:
  - One idle cycle.
  - If cur==end_addr: go to FINISH.
  - Otherwise: cur++ and go to RD_REQ.
- FINISH: busy=0, done=1, pass as defined above; return to IDLE the same cycle.
- Range: end_addr < start_addr wraps through 2^ADDR_W-1 to 0. start_addr == end_addr gives exactly one write and one read. Sweep length = ((end-start) mod 2^ADDR_W) + 1.
- Throughput: minimum 2 cycles per access (request plus gap) when req_rdy is already high.
- wdata is don't-care-stable (driven as SEED^cur) during reads. req_rnw, req_addr and wdata never change while req_vld=1 && !req_rdy.

Optional Feature:
MEM_BIST_TIMEOUT_EN:
- Defined:
  - Adds output timeout (1 bit, reset 0) and a watchdog counter that is cleared on every accept and on every entry to a REQ state.
  - If req_vld stays high without req_rdy for TIMEOUT_CYC consecutive cycles: req_vld drops the next cycle, timeout=1, and the FSM goes to FINISH (done=1, pass=0).
  - timeout clears on the next accepted start.
- Undefined: no timeout port and no counter; the FSM waits on req_rdy indefinitely.

Test Plan:
1. Correct memory model, req_rdy after a 2-cycle wait; start_addr=1, end_addr=3 -> writes of 0xC0DE0001/2/3 to addresses 1, 2, 3, then reads of 1, 2, 3; done=1, pass=1, err_cnt=0.
2. Model corrupts rdata at address 2 on reads -> err_cnt=1, first_err_addr=2, pass=0, done=1.
3. Wrap: start_addr=0xE, end_addr=0x1 -> write order E, F, 0, 1, then read order E, F, 0, 1; exactly 4 of each.
4. start_addr=end_addr=5, req_rdy tied 1 -> exactly 1 write then 1 read, 2 cycles each; a start pulse mid-sweep is ignored (busy stays 1, addresses unchanged).
5. rst=1 asserted while in WR_REQ with req_rdy=0 -> next cycle req_vld=0, busy=0, done=0; a subsequent start runs a full clean sweep.
6. MEM_BIST_TIMEOUT_EN defined, req_rdy tied 0 -> after 64 cycles of req_vld high: timeout=1, done=1, pass=0, req_vld=0.
